// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and defaults for the execute/writeback slice
// Purpose: operation codes, control-FSM state encoding and default widths.
// Ports: none (package).
package cpu_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int NREG_DEF   = 16;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_MUL  = 3'b010,
      OP_AND  = 3'b011,
      OP_OR   = 3'b100,
      OP_XOR  = 3'b101,
      OP_SHL  = 3'b110,
      OP_PASS = 3'b111
   } op_t;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_MUL_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/exec_wb_unit_if.sv
// rtl/exec_wb_unit_if.sv - request/result bundle of the execute/writeback unit
// Purpose: groups the request handshake (in_*/op/rd/operands) and the result pulse (out_*).
// Ports: none; master drives requests and observes results, slave is the unit.
interface exec_wb_unit_if import cpu_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREG   = NREG_DEF
);
   localparam int RD_W = $clog2(NREG);

   logic              in_valid;
   logic              in_ready;
   op_t               op;
   logic [RD_W-1:0]   rd;
   logic [DATA_W-1:0] rs1;
   logic [DATA_W-1:0] rs2;
   logic              cin;
   logic              bin;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [RD_W-1:0]   out_rd;
   logic              out_cout;

   modport master (
      output in_valid, op, rd, rs1, rs2, cin, bin,
      input  in_ready, out_valid, out_data, out_rd, out_cout
   );

   modport slave (
      input  in_valid, op, rd, rs1, rs2, cin, bin,
      output in_ready, out_valid, out_data, out_rd, out_cout
   );

endinterface

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - iterative shift-add unsigned multiplier, one product bit per cycle
// Purpose: start loads the operands; DATA_W cycles later done pulses with the full product.
// Ports: clk, rst (sync, active-high), start, a, b in; done, product (valid while done) out.
module seq_mul #(
   parameter int DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  done,
   output logic [2*DATA_W-1:0]   product
);
   localparam int CNT_W = $clog2(DATA_W);

   logic                busy;
   logic [CNT_W-1:0]    cnt;
   logic [2*DATA_W-1:0] mcand;
   logic [DATA_W-1:0]   mplier;
   logic [2*DATA_W-1:0] acc;
   logic [2*DATA_W-1:0] partial;

   // product is the accumulator after this cycle's step, so the result is
   // available on the same edge that retires the last multiplier bit.
   assign partial = mplier[0] ? mcand : '0;
   assign product = acc + partial;
   assign done    = busy && (cnt == CNT_W'(DATA_W - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= '0;
         mcand  <= {{DATA_W{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
      end else if (busy) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/exec_wb_unit.sv
// rtl/exec_wb_unit.sv - single-issue ALU with sequential multiplier and register-file writeback
// Purpose: executes one op per cycle (MUL takes DATA_W+1 cycles), pulses the result and
//          writes it into the register file on the following edge.
// Ports: clk, rst (sync, active-high); bus (exec_wb_unit_if.slave) request/result;
//        regs out, current register-file contents.
module exec_wb_unit import cpu_pkg::*; #(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int NREG    = NREG_DEF,
   parameter int ZERO_R0 = 0
) (
   input  logic              clk,
   input  logic              rst,
   exec_wb_unit_if.slave     bus,
   output logic [DATA_W-1:0] regs [NREG]
);
   localparam int RD_W = $clog2(NREG);
   localparam int SH_W = $clog2(DATA_W);

   localparam logic [0:0] S_IDLE     = ST_IDLE;
   localparam logic [0:0] S_MUL_BUSY = ST_MUL_BUSY;

   logic [0:0]          state;
   logic                accept;
   logic                mul_start;
   logic                mul_done;
   logic [2*DATA_W-1:0] mul_product;
   logic [RD_W-1:0]     mul_rd;
   logic [DATA_W:0]     alu_wide;
   logic [DATA_W-1:0]   alu_data;
   logic                alu_cout;

   // Gated by rst so a request in a reset cycle is never taken.
   assign bus.in_ready = (state == S_IDLE) && !rst;
   assign accept       = bus.in_valid && bus.in_ready;
   assign mul_start    = accept && (bus.op == OP_MUL);

   always_comb begin
      alu_wide = '0;
      alu_data = '0;
      alu_cout = 1'b0;
      case (bus.op)
         OP_ADD: begin
            alu_wide = {1'b0, bus.rs1} + {1'b0, bus.rs2} + (DATA_W+1)'(bus.cin);
            alu_data = alu_wide[DATA_W-1:0];
            alu_cout = alu_wide[DATA_W];
         end
         OP_SUB: begin
            // A negative difference wraps into bit DATA_W, which is the borrow.
            alu_wide = {1'b0, bus.rs1} - {1'b0, bus.rs2} - (DATA_W+1)'(bus.bin);
            alu_data = alu_wide[DATA_W-1:0];
            alu_cout = alu_wide[DATA_W];
         end
         OP_AND:  alu_data = bus.rs1 & bus.rs2;
         OP_OR:   alu_data = bus.rs1 | bus.rs2;
         OP_XOR:  alu_data = bus.rs1 ^ bus.rs2;
         OP_SHL:  alu_data = bus.rs1 << bus.rs2[SH_W-1:0];
         OP_PASS: alu_data = bus.rs2;
         default: alu_data = '0;
      endcase
   end

   seq_mul #(.DATA_W(DATA_W)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (bus.rs1),
      .b       (bus.rs2),
      .done    (mul_done),
      .product (mul_product)
   );

   // Control FSM and result register; out_* hold their value between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         mul_rd        <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_rd    <= '0;
         bus.out_cout  <= 1'b0;
      end else begin
         bus.out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (mul_start) begin
                  state  <= S_MUL_BUSY;
                  mul_rd <= bus.rd;
               end else if (accept) begin
                  bus.out_valid <= 1'b1;
                  bus.out_data  <= alu_data;
                  bus.out_rd    <= bus.rd;
                  bus.out_cout  <= alu_cout;
               end
            end
            S_MUL_BUSY: begin
               if (mul_done) begin
                  state         <= S_IDLE;
                  bus.out_valid <= 1'b1;
                  bus.out_data  <= mul_product[DATA_W-1:0];
                  bus.out_rd    <= mul_rd;
                  bus.out_cout  <= |mul_product[2*DATA_W-1:DATA_W];
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Writeback trails the result pulse by one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (bus.out_valid && !((ZERO_R0 != 0) && (bus.out_rd == '0))) begin
         regs[bus.out_rd] <= bus.out_data;
      end
   end

endmodule

// File: tb/tb_exec_wb_unit.sv
// tb/tb_exec_wb_unit.sv - directed scoreboard bench for exec_wb_unit
module tb_exec_wb_unit;
   import cpu_pkg::*;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  rd;
      logic        cout;
      int          due;
   } exp_t;

   logic        clk;
   logic        rst;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   exp_t        sb [$];
   exp_t        e_mon;
   logic        wb_pending = 1'b0;
   logic [3:0]  wb_rd;
   logic [15:0] wb_data;
   logic [15:0] regs1 [16];
   logic [15:0] regs2 [16];

   exec_wb_unit_if #(.DATA_W(16), .NREG(16)) bus1 ();
   exec_wb_unit_if #(.DATA_W(16), .NREG(16)) bus2 ();

   exec_wb_unit #(.DATA_W(16), .NREG(16), .ZERO_R0(0)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .regs(regs1));
   exec_wb_unit #(.DATA_W(16), .NREG(16), .ZERO_R0(1)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2), .regs(regs2));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: {cout, data} computed with wide integer arithmetic.
   function automatic logic [16:0] model(input op_t op, input logic [15:0] a,
                                         input logic [15:0] b, input logic c);
      int     s;
      longint p;
      logic [15:0] sh;
      case (op)
         OP_ADD:  begin s = int'(a) + int'(b) + int'(c); return {s > 65535, s[15:0]}; end
         OP_SUB:  begin s = int'(a) - int'(b) - int'(c); return {s < 0, s[15:0]}; end
         OP_MUL:  begin p = longint'(a) * longint'(b); return {p > 65535, p[15:0]}; end
         OP_AND:  return {1'b0, a & b};
         OP_OR:   return {1'b0, a | b};
         OP_XOR:  return {1'b0, a ^ b};
         OP_SHL:  begin sh = a << b[3:0]; return {1'b0, sh}; end
         default: return {1'b0, b};
      endcase
   endfunction

   // Presents a request on bus1 and holds it until accepted; pushes the expectation.
   task automatic issue(input op_t op, input logic [3:0] rd, input logic [15:0] a,
                        input logic [15:0] b, input logic c, output int waited);
      exp_t        e;
      logic [16:0] m;
      waited = 0;
      @(negedge clk);
      bus1.in_valid = 1'b1;
      bus1.op = op;
      bus1.rd = rd;
      bus1.rs1 = a;
      bus1.rs2 = b;
      bus1.cin = c;
      bus1.bin = c;
      while (bus1.in_ready !== 1'b1 && waited < 100) begin
         waited++;
         @(negedge clk);
      end
      if (waited >= 100) begin
         checks++;
         failures++;
         $error("FAIL accept_timeout observed=%0d expected=<100", waited);
      end
      @(posedge clk);
      #1;
      m = model(op, a, b, c);
      e.data = m[15:0];
      e.cout = m[16];
      e.rd = rd;
      e.due = cyc + ((op == OP_MUL) ? 16 : 0);
      sb.push_back(e);
      bus1.in_valid = 1'b0;
   endtask

   // Result monitor for dut1: pops the scoreboard and checks the following writeback.
   always @(negedge clk) begin
      if (wb_pending) begin
         check("wb_regs", regs1[wb_rd], wb_data);
         wb_pending = 1'b0;
      end
      if (bus1.out_valid === 1'b1) begin
         checks++;
         assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_out_valid observed=1 expected=0 rd=%0d", bus1.out_rd);
         end
         if (sb.size() != 0) begin
            e_mon = sb.pop_front();
            check("out_data", bus1.out_data, e_mon.data);
            check("out_rd", bus1.out_rd, e_mon.rd);
            check("out_cout", bus1.out_cout, e_mon.cout);
            check("latency_cycle", cyc, e_mon.due);
            wb_pending = 1'b1;
            wb_rd = e_mon.rd;
            wb_data = e_mon.data;
         end
      end
   end

   initial begin
      int w;
      rst = 1'b1;
      bus1.in_valid = 1'b0; bus1.op = OP_ADD; bus1.rd = '0; bus1.rs1 = '0;
      bus1.rs2 = '0; bus1.cin = 1'b0; bus1.bin = 1'b0;
      bus2.in_valid = 1'b0; bus2.op = OP_ADD; bus2.rd = '0; bus2.rs1 = '0;
      bus2.rs2 = '0; bus2.cin = 1'b0; bus2.bin = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", bus1.in_ready, 0);
      check("rst_out_valid", bus1.out_valid, 0);
      check("rst_out_data", bus1.out_data, 0);
      check("rst_out_rd", bus1.out_rd, 0);
      check("rst_out_cout", bus1.out_cout, 0);
      check("rst_regs0", regs1[0], 0);
      check("rst_regs15", regs1[15], 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", bus1.in_ready, 1);

      issue(OP_ADD, 4'd3, 16'd120, 16'd10, 1'b0, w);
      issue(OP_SUB, 4'd5, 16'd10, 16'd120, 1'b0, w);
      issue(OP_ADD, 4'd6, 16'hFFFF, 16'h0000, 1'b1, w);
      issue(OP_SUB, 4'd2, 16'd5, 16'd5, 1'b1, w);
      issue(OP_MUL, 4'd7, 16'd300, 16'd300, 1'b0, w);
      issue(OP_ADD, 4'd4, 16'd1, 16'd2, 1'b0, w);
      check("mul_busy_cycles", w, 16);
      issue(OP_MUL, 4'd12, 16'd7, 16'd9, 1'b0, w);
      issue(OP_AND, 4'd8, 16'hF0F0, 16'hFF00, 1'b0, w);
      check("mul2_busy_cycles", w, 16);
      issue(OP_OR, 4'd9, 16'hF0F0, 16'h0F00, 1'b0, w);
      issue(OP_XOR, 4'd10, 16'hF0F0, 16'hFF00, 1'b0, w);
      issue(OP_SHL, 4'd11, 16'd1, 16'd4, 1'b0, w);
      issue(OP_SHL, 4'd14, 16'd3, 16'h0013, 1'b0, w);
      issue(OP_MUL, 4'd15, 16'hFFFF, 16'hFFFF, 1'b0, w);
      issue(OP_PASS, 4'd1, 16'h1111, 16'hABCD, 1'b0, w);
      repeat (4) @(negedge clk);
      check("sb_drained", sb.size(), 0);

      // Reset five cycles into a multiply, with a request presented during reset.
      issue(OP_MUL, 4'd13, 16'd300, 16'd300, 1'b0, w);
      void'(sb.pop_back());
      repeat (4) @(negedge clk);
      rst = 1'b1;
      bus1.in_valid = 1'b1; bus1.op = OP_ADD; bus1.rd = 4'd2;
      bus1.rs1 = 16'd9; bus1.rs2 = 16'd9;
      @(negedge clk);
      check("rst_mid_in_ready", bus1.in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      bus1.in_valid = 1'b0;
      @(negedge clk);
      check("after_abort_in_ready", bus1.in_ready, 1);
      check("after_abort_out_valid", bus1.out_valid, 0);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("after_abort_regs%0d", i), regs1[i], 0);
      end
      repeat (25) @(negedge clk);
      check("abort_no_write_rd13", regs1[13], 0);
      check("abort_sb_empty", sb.size(), 0);

      // Hardwired-zero register 0 on dut2.
      check("z_in_ready", bus2.in_ready, 1);
      bus2.in_valid = 1'b1; bus2.op = OP_PASS; bus2.rd = 4'd0; bus2.rs2 = 16'hBEEF;
      @(negedge clk);
      bus2.rd = 4'd1; bus2.rs2 = 16'h1234;
      check("z_out_valid", bus2.out_valid, 1);
      check("z_out_data", bus2.out_data, 16'hBEEF);
      check("z_out_rd", bus2.out_rd, 0);
      @(negedge clk);
      bus2.in_valid = 1'b0;
      check("z_regs0", regs2[0], 0);
      check("z_out_data2", bus2.out_data, 16'h1234);
      @(negedge clk);
      check("z_regs1", regs2[1], 16'h1234);
      check("z_hold_valid", bus2.out_valid, 0);
      check("z_hold_data", bus2.out_data, 16'h1234);
      check("z_regs0_final", regs2[0], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exec_wb_unit.md
EXEC_WB_UNIT -- requirements
Module: exec_wb_unit

Interface
REQ-001 Parameter DATA_W, default 16, operand/result/register width (>=4).
REQ-002 Parameter NREG, default 16, register-file entries (power of 2, >=2); RD_W = log2(NREG).
REQ-003 Parameter ZERO_R0, default 0; when 1, register 0 is hardwired to zero.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  unit can accept; transfer when in_valid & in_ready at a rising edge.
REQ-008 op  in  3  operation code (cpu_pkg op_t).
REQ-009 rd  in  RD_W  destination register index.
REQ-010 rs1, rs2  in  DATA_W each  operands.
REQ-011 cin, bin  in  1 each  carry-in (ADD), borrow-in (SUB).
REQ-012 out_valid  out  1  one-cycle result pulse; no backpressure.
REQ-013 out_data  out  DATA_W  result; out_rd  out  RD_W  destination; out_cout  out  1  carry/borrow/overflow flag.
REQ-014 regs  out  NREG x DATA_W  unpacked array, current register-file contents.

Function
REQ-015 op codes: 000 ADD rs1+rs2+cin; 001 SUB rs1-rs2-bin; 010 MUL rs1*rs2; 011 AND; 100 OR; 101 XOR; 110 SHL rs1<<rs2[log2(DATA_W)-1:0]; 111 PASS rs2.
REQ-016 Arithmetic is unsigned and computed at DATA_W+1 bits; ADD out_cout = bit DATA_W; SUB out_cout = 1 when borrow is generated.
REQ-017 MUL out_data = low DATA_W bits of the 2*DATA_W product; out_cout = 1 iff the high half is nonzero.
REQ-018 Logic, SHL and PASS drive out_cout = 0.
REQ-019 Single-cycle ops accepted at edge T: out_valid, out_data, out_rd and out_cout are valid in the cycle after T (latency 1); the unit accepts back-to-back, one per cycle.
REQ-020 MUL uses iterative shift-add, one product bit per cycle: accepted at edge T, out_valid is asserted in the cycle after edge T+DATA_W (latency DATA_W+1).
REQ-021 State machine IDLE/MUL_BUSY: IDLE->MUL_BUSY on MUL accept; MUL_BUSY->IDLE on the edge that produces the MUL result; in_ready = (state == IDLE).
REQ-022 in_ready is high again in the same cycle as the MUL out_valid pulse; a request accepted then completes normally.
REQ-023 Requests presented while in_ready = 0 are ignored, and operands are not sampled.
REQ-024 Writeback: in every cycle with out_valid = 1, regs[out_rd] <= out_data at the next edge; the new value is visible on regs one cycle after the out_valid pulse.
REQ-025 When ZERO_R0 = 1, writes to index 0 are discarded and regs[0] reads 0; out_valid/out_data still pulse.
REQ-026 out_data, out_rd and out_cout hold their last values when out_valid = 0.

Reset
REQ-027 While rst = 1 at an edge: state = IDLE, out_valid = 0, out_data = 0, out_rd = 0, out_cout = 0, all regs = 0, multiplier datapath cleared.
REQ-028 in_ready = 0 while rst is high and 1 in the first cycle after reset.
REQ-029 Reset during MUL_BUSY aborts the multiply: no out_valid and no register write.
REQ-030 A request presented in the same cycle as rst = 1 is not accepted.

Structure
REQ-031 Package cpu_pkg holds op_t (3-bit enum), the state enum, and default localparams DATA_W_DEF = 16 and NREG_DEF = 16.
REQ-032 The shift-add multiplier is a sub-module seq_mul (start/done handshake, parameter DATA_W); ALU, control FSM and register file stay in exec_wb_unit.

Verification
REQ-033 ADD rs1=120, rs2=10, cin=0, rd=3 -> next cycle out_valid=1, out_data=130, out_cout=0; regs[3]=130 one cycle later.
REQ-034 SUB rs1=10, rs2=120, bin=0, rd=5 (DATA_W=16) -> out_data=65426, out_cout=1, regs[5]=65426.
REQ-035 MUL 300*300, rd=7 (DATA_W=16) -> out_valid 17 cycles after accept, out_data=24464, out_cout=1; in_ready=0 for 16 cycles; an in_valid held high during that time is accepted only when in_ready returns.
REQ-036 Back-to-back AND, OR, XOR, SHL (rs1=1, rs2=4 -> 16) -> four consecutive out_valid pulses with correct data and four writes.
REQ-037 rst asserted 5 cycles into a MUL -> no out_valid, all regs=0, in_ready=1 on the first cycle after reset.
REQ-038 ZERO_R0=1, PASS rs2=0xBEEF, rd=0 -> out_valid pulses with 0xBEEF, regs[0] stays 0.
